// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_ctrl
//  Purpose  : Iterative radix-2 multiply/divide unit with architectural
//             HI/LO registers. One bit per cycle: 32 CALC cycles, then one
//             FIX cycle for sign correction and the HI/LO write.
//             Accept-to-done latency is 34 cycles.
//  Ports    : clk    - clock, rising edge
//             reset  - asynchronous active-low reset
//             start  - one-cycle request to begin an operation (IDLE only)
//             op     - 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//             src_a  - multiplicand / dividend
//             src_b  - multiplier / divisor
//             flush  - aborts an in-flight operation, HI/LO left untouched
//             wr_hi  - MTHI write strobe (honoured only in IDLE)
//             wr_lo  - MTLO write strobe (honoured only in IDLE)
//             wdata  - MTHI/MTLO write data
//             busy   - operation in flight
//             done   - one-cycle pulse, HI/LO already hold the result
//             hi, lo - architectural HI/LO registers
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam logic [4:0] C_LAST_STEP = 5'd31;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_is_div;
    logic        r_sign_a;      // operand signs, only ever set for signed ops
    logic        r_sign_b;
    logic        r_divz;
    logic [31:0] r_opa;
    logic [31:0] r_opb;
    logic [31:0] r_orig_a;      // raw dividend, returned in HI on divide by zero
    logic [63:0] r_acc;
    logic [4:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;

    logic        w_accept;
    logic        w_signed_op;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_step;
    logic [32:0] w_div_shift;
    logic [32:0] w_div_diff;
    logic        w_div_ge;
    logic [63:0] w_div_step;
    logic        w_neg_res;
    logic [63:0] w_prod_fix;
    logic [31:0] w_quot_fix;
    logic [31:0] w_rem_fix;

    // ------------------------------------------------------------------
    // Operand conditioning at acceptance
    // ------------------------------------------------------------------
    assign w_accept    = (r_state == S_IDLE) && start && !flush;
    assign w_signed_op = !op[0];
    assign w_abs_a     = (w_signed_op && src_a[31]) ? (~src_a + 32'd1) : src_a;
    assign w_abs_b     = (w_signed_op && src_b[31]) ? (~src_b + 32'd1) : src_b;

    // ------------------------------------------------------------------
    // One radix-2 step
    // Multiply: acc = {partial, multiplier}; add multiplicand to the upper
    // half when the current multiplier bit is set, then shift right with
    // the adder carry entering at the top.
    // Divide: acc = {remainder, quotient}; the shifted remainder needs 33
    // bits because it can reach 2*divisor-1.
    // ------------------------------------------------------------------
    assign w_mul_sum   = {1'b0, r_acc[63:32]} + {1'b0, r_opa};
    assign w_mul_step  = r_acc[0] ? {w_mul_sum, r_acc[31:1]}
                                  : {1'b0, r_acc[63:1]};

    assign w_div_shift = {r_acc[63:32], r_acc[31]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_opb});
    assign w_div_diff  = w_div_shift - {1'b0, r_opb};
    assign w_div_step  = w_div_ge ? {w_div_diff[31:0], r_acc[30:0], 1'b1}
                                  : {w_div_shift[31:0], r_acc[30:0], 1'b0};

    // ------------------------------------------------------------------
    // Sign correction applied on the FIX edge
    // ------------------------------------------------------------------
    assign w_neg_res  = r_sign_a ^ r_sign_b;
    assign w_prod_fix = w_neg_res ? (~r_acc + 64'd1) : r_acc;
    assign w_quot_fix = w_neg_res ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
    assign w_rem_fix  = r_sign_a ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                if (flush) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == C_LAST_STEP) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and architectural registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_is_div <= 1'b0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_divz   <= 1'b0;
            r_opa    <= 32'd0;
            r_opb    <= 32'd0;
            r_orig_a <= 32'd0;
            r_acc    <= 64'd0;
            r_cnt    <= 5'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if (w_accept) begin
                r_is_div <= op[1];
                r_sign_a <= w_signed_op && src_a[31];
                r_sign_b <= w_signed_op && src_b[31];
                r_divz   <= (src_b == 32'd0);
                r_opa    <= w_abs_a;
                r_opb    <= w_abs_b;
                r_orig_a <= src_a;
                // Multiply seeds the accumulator with the multiplier,
                // divide seeds it with the dividend.
                r_acc    <= {32'd0, (op[1] ? w_abs_a : w_abs_b)};
                r_cnt    <= 5'd0;
            end else if ((r_state == S_CALC) && !flush) begin
                r_acc <= r_is_div ? w_div_step : w_mul_step;
                r_cnt <= r_cnt + 5'd1;
            end

            // MTHI/MTLO in IDLE coexist with an accepted start; the
            // operation overwrites both registers on its FIX edge.
            if (r_state == S_IDLE) begin
                if (wr_hi) begin
                    r_hi <= wdata;
                end
                if (wr_lo) begin
                    r_lo <= wdata;
                end
            end else if ((r_state == S_FIX) && !flush) begin
                r_done <= 1'b1;
                if (!r_is_div) begin
                    r_hi <= w_prod_fix[63:32];
                    r_lo <= w_prod_fix[31:0];
                end else if (r_divz) begin
                    r_hi <= r_orig_a;
                    r_lo <= 32'hFFFF_FFFF;
                end else begin
                    r_hi <= w_rem_fix;
                    r_lo <= w_quot_fix;
                end
            end
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 The block SHALL have ports clk (in, 1, sole clock, rising edge) and reset (in, 1, asynchronous active-low reset).
REQ-002 The block SHALL have input start (1), a one-cycle request to begin an operation.
REQ-003 The block SHALL have input op (2), operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-004 The block SHALL have inputs src_a (32, multiplicand/dividend) and src_b (32, multiplier/divisor).
REQ-005 The block SHALL have input flush (1), which aborts any in-flight operation.
REQ-006 The block SHALL have inputs wr_hi and wr_lo (1 each) and wdata (32), used for MTHI/MTLO writes.
REQ-007 The block SHALL have output busy (1), high while an operation is in flight.
REQ-008 The block SHALL have output done (1), a one-cycle pulse marking a completed operation.
REQ-009 The block SHALL have outputs hi and lo (32 each), the architectural HI/LO registers.

Function
REQ-010 The state machine SHALL have exactly three states: IDLE, CALC and FIX.
REQ-011 busy SHALL equal (state != IDLE).
REQ-012 In IDLE with start=1 and flush=0, the block SHALL latch op, |src_a| and |src_b| (absolute values for signed ops, raw values for unsigned), record both operand signs, clear a 5-bit iteration counter, and enter CALC.
REQ-013 start SHALL be ignored while busy=1.
REQ-014 If start and flush are both high in the same cycle, the request SHALL NOT be accepted.
REQ-015 In CALC, each cycle SHALL perform one radix-2 step:
- multiply: shift-add on a 64-bit accumulator;
- divide: restoring shift-subtract on a 64-bit remainder/quotient pair.
REQ-016 The counter SHALL increment once per CALC cycle; the edge on which count==31 SHALL move the state to FIX (exactly 32 CALC cycles).
REQ-017 On the FIX edge the block SHALL sign-correct the result and write hi and lo, then return to IDLE.
REQ-018 done SHALL be registered and high for exactly the one cycle after the FIX edge, when hi/lo already hold the new values.
REQ-019 Total latency SHALL be 34 cycles from the accepting edge to the done-high cycle.
REQ-020 Multiply sign correction: for MULT with differing operand signs, the 64-bit product SHALL be two's-complement negated; then hi = product[63:32] and lo = product[31:0].
REQ-021 Divide sign correction for DIV:
- the quotient SHALL be negated if the operand signs differ;
- the remainder SHALL take the sign of the dividend;
- then lo = quotient and hi = remainder.
REQ-022 Divide by zero (src_b==0) SHALL still take 34 cycles and produce lo=32'hFFFF_FFFF and hi=src_a (original, uncorrected value), for both DIV and DIVU.
REQ-023 The signed overflow case DIV 0x80000000 / 0xFFFFFFFF SHALL produce lo=0x80000000 and hi=0.
REQ-024 flush in CALC or FIX SHALL return the state to IDLE on the next edge with hi/lo unchanged and no done pulse.
REQ-025 flush in IDLE SHALL have no effect.
REQ-026 wr_hi/wr_lo SHALL update hi/lo from wdata only when state==IDLE; they SHALL be ignored while busy.
REQ-027 If wr_hi/wr_lo and an accepted start occur in the same cycle, the write SHALL take effect and the operation SHALL later overwrite both registers.
REQ-028 wr_hi and wr_lo high together SHALL write wdata to both registers.
REQ-029 No output SHALL depend combinationally on start, op, src_a or src_b.

Reset
REQ-030 While reset=0 the block SHALL asynchronously force: state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0, and all internal operand/accumulator registers to 0.
REQ-031 Reset asserted mid-operation SHALL discard the operation; after release the block SHALL accept a new start on the first edge.

Verification
REQ-032 MULT src_a=0xFFFFFFFE, src_b=3 -> done in cycle 34; hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy high for cycles 1-33.
REQ-033 DIVU 100/7 -> lo=14, hi=2.
REQ-034 DIV 0xFFFFFFF9 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-035 Divide by zero, DIVU 0x1234/0 -> lo=0xFFFFFFFF, hi=0x1234.
REQ-036 Start MULTU 5*5 with hi=lo=0xA5A5A5A5 preloaded, flush at cycle 10 -> busy=0 at cycle 11, hi=lo=0xA5A5A5A5, no done; a new start at cycle 11 is accepted.
REQ-037 Attempted writes and restarts:
- wr_lo=1 with wdata=7 while busy -> lo unchanged;
- start during busy -> ignored, done pulses once only;
- reset low at cycle 20 -> all outputs 0 immediately.
